runway_wind_tick: RTL and testbench

Upstream conditioning stage for the runway landing-light pattern FSM. Takes the raw wind-direction switches, then synchronizes, debounces and registers them into a stable 2-bit wind mode. Generates the slow one-cycle `step` enable that tells the pattern FSM when to advance. On every accepted wind change, it restarts the step timer so the new pattern begins phase-aligned.

---
 rtl/runway_wind_tick.sv | 131 +++++++++++++
 tb/tb_runway_wind_tick.sv | 132 +++++++++++++
 2 files changed

// File: rtl/runway_wind_tick.sv
// runway_wind_tick: conditions the raw wind switches into a stable, registered
// 2-bit wind mode and generates the slow one-cycle step enable for the runway
// landing-light pattern FSM.
//
// When a wind change is accepted, the step timer restarts. This keeps the new
// pattern phase-aligned.
//
// Ports:
//   clk      in   system clock, rising-edge active
//   reset    in   asynchronous, active-high reset
//   SW       in   [1:0] raw wind switches (00 calm, 01 R->L, 10 L->R, 11 passed through)
//   hold     in   synchronous freeze of the step timer while high
//   wind     out  [1:0] debounced, registered wind mode
//   step     out  one-cycle advance pulse, period CLK_DIV cycles
//   wind_chg out  one-cycle pulse in the cycle wind takes a new value
module runway_wind_tick #(
    parameter int unsigned CLK_DIV    = 25_000_000,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] SW,
    input  logic       hold,
    output logic [1:0] wind,
    output logic       step,
    output logic       wind_chg
);

    localparam int unsigned DW = $clog2(DEB_CYCLES);
    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_t;

    deb_state_t    state, state_nxt;
    logic [1:0]    s1, s2;
    logic [1:0]    cand, cand_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [TW-1:0] tcnt, tcnt_nxt;
    logic [1:0]    wind_nxt;
    logic          step_nxt;
    logic          wind_chg_nxt;
    logic          accept_c;

    // State register: synchronizer, debouncer, step timer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= STABLE;
            s1       <= 2'b00;
            s2       <= 2'b00;
            cand     <= 2'b00;
            dcnt     <= '0;
            tcnt     <= '0;
            wind     <= 2'b00;
            step     <= 1'b0;
            wind_chg <= 1'b0;
        end else begin
            state    <= state_nxt;
            s1       <= SW;
            s2       <= s1;
            cand     <= cand_nxt;
            dcnt     <= dcnt_nxt;
            tcnt     <= tcnt_nxt;
            wind     <= wind_nxt;
            step     <= step_nxt;
            wind_chg <= wind_chg_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        cand_nxt     = cand;
        dcnt_nxt     = dcnt;
        tcnt_nxt     = tcnt;
        wind_nxt     = wind;
        step_nxt     = 1'b0;
        wind_chg_nxt = 1'b0;
        accept_c     = 1'b0;

        // Candidate tracking: any change restarts the stability count, which saturates
        if (s2 != cand) begin
            cand_nxt = s2;
            dcnt_nxt = '0;
        end else if (dcnt != DMAX) begin
            dcnt_nxt = dcnt + DW'(1);
        end

        // SETTLING exactly mirrors cand != wind, so acceptance is gated on it
        accept_c = (state == SETTLING) && (s2 == cand) && (dcnt == DMAX);

        case (state)
            STABLE: begin
                // cand == wind here, so a differing s2 is a genuinely new value
                if (s2 != cand) begin
                    state_nxt = SETTLING;
                end
            end
            SETTLING: begin
                if (accept_c) begin
                    state_nxt = STABLE;
                end else if ((s2 != cand) && (s2 == wind)) begin
                    // Bounced back to the current wind before acceptance
                    state_nxt = STABLE;
                end
            end
        endcase

        if (accept_c) begin
            wind_nxt     = cand;
            wind_chg_nxt = 1'b1;
        end

        // Step timer: a wind change restarts the phase and suppresses a coincident step
        if (accept_c) begin
            tcnt_nxt = '0;
        end else if (hold) begin
            tcnt_nxt = tcnt;
        end else if (tcnt == TMAX) begin
            tcnt_nxt = '0;
            step_nxt = 1'b1;
        end else begin
            tcnt_nxt = tcnt + TW'(1);
        end
    end

endmodule

// File: tb/tb_runway_wind_tick.sv
// Directed bench for runway_wind_tick with CLK_DIV=8, DEB_CYCLES=4.
// Inputs change just after the falling edge. Outputs are sampled on the
// falling edge that follows each rising edge.
module tb_runway_wind_tick;

    logic       clk;
    logic       reset;
    logic [1:0] SW;
    logic       hold;
    logic [1:0] wind;
    logic       step;
    logic       wind_chg;

    int checks = 0;
    int errors = 0;

    runway_wind_tick #(
        .CLK_DIV    (8),
        .DEB_CYCLES (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .SW       (SW),
        .hold     (hold),
        .wind     (wind),
        .step     (step),
        .wind_chg (wind_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then check all outputs on the following falling edge
    task automatic edge_chk(input logic s, input logic c, input logic [1:0] w, input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_step"}, {1'b0, step}, {1'b0, s});
        chk({tag, "_chg"}, {1'b0, wind_chg}, {1'b0, c});
        chk({tag, "_wind"}, wind, w);
    endtask

    task automatic quiet(input int n, input logic [1:0] w, input string tag);
        for (int i = 0; i < n; i++) edge_chk(1'b0, 1'b0, w, tag);
    endtask

    initial begin
        reset = 1'b1;
        SW    = 2'b00;
        hold  = 1'b0;

        // Reset then idle: steps after edges 8, 16, 24
        @(negedge clk);
        chk("rst_wind", wind, 2'b00);
        chk("rst_step", {1'b0, step}, 2'b00);
        chk("rst_chg", {1'b0, wind_chg}, 2'b00);
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) edge_chk(k % 8 == 0, 1'b0, 2'b00, "idle");

        // Clean change 00->01: accepted on edge 7, next step 8 edges later
        SW = 2'b01;
        quiet(6, 2'b00, "clean_pre");
        edge_chk(1'b0, 1'b1, 2'b01, "clean_acc");
        quiet(7, 2'b01, "clean_post");
        edge_chk(1'b1, 1'b0, 2'b01, "clean_step");

        // Async reset while SETTLING toward 10 with wind=01
        SW = 2'b10;
        quiet(3, 2'b01, "settle");
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wind", wind, 2'b00);
        chk("arst_step", {1'b0, step}, 2'b00);
        chk("arst_chg", {1'b0, wind_chg}, 2'b00);
        SW = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 24; k++) edge_chk(k % 8 == 0, 1'b0, 2'b00, "idle2");

        // Bounce: 10 for 3 samples, 00 for 2, then 10 steady from edge 6
        SW = 2'b10;
        quiet(3, 2'b00, "bounce_glitch");
        SW = 2'b00;
        quiet(2, 2'b00, "bounce_back");
        SW = 2'b10;
        quiet(2, 2'b00, "bounce_pre");
        edge_chk(1'b1, 1'b0, 2'b00, "bounce_step");
        quiet(3, 2'b00, "bounce_wait");
        edge_chk(1'b0, 1'b1, 2'b10, "bounce_acc");
        quiet(7, 2'b10, "bounce_post");
        edge_chk(1'b1, 1'b0, 2'b10, "bounce_step2");

        // Collision: acceptance lands on the edge where tcnt==7
        quiet(1, 2'b10, "coll_lead");
        SW = 2'b01;
        quiet(6, 2'b10, "coll_pre");
        edge_chk(1'b0, 1'b1, 2'b01, "coll_acc");
        quiet(7, 2'b01, "coll_post");
        edge_chk(1'b1, 1'b0, 2'b01, "coll_step");

        // Hold for 5 cycles mid-period: interval stretches to 13
        quiet(3, 2'b01, "hold_lead");
        hold = 1'b1;
        quiet(5, 2'b01, "hold_on");
        hold = 1'b0;
        quiet(4, 2'b01, "hold_tail");
        edge_chk(1'b1, 1'b0, 2'b01, "hold_step");

        // SW=11 during hold with tcnt=3: acceptance still clears tcnt
        quiet(3, 2'b01, "hold2_lead");
        hold = 1'b1;
        SW   = 2'b11;
        quiet(6, 2'b01, "hold2_pre");
        edge_chk(1'b0, 1'b1, 2'b11, "hold2_acc");
        quiet(2, 2'b11, "hold2_held");
        hold = 1'b0;
        quiet(7, 2'b11, "hold2_run");
        edge_chk(1'b1, 1'b0, 2'b11, "hold2_step");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
